// File: rtl/conv_accel_top.sv
// Valid 2-D convolution accelerator: S x S MAC tile over internal IFM/weight memories into OFM memory.
// Optional OFM_SAT_EN: saturate OFM words to signed 2*DATA_WIDTH range instead of wrapping.
module conv_accel_top #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int BUFFER_COUNT  = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int INOUT_WIDTH   = 128,
  parameter int IFM_SIZE      = 210,
  parameter int IFM_CHANNEL   = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int NO_FILTER     = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);
  localparam int S         = SYSTOLIC_SIZE;
  localparam int OFM_SIZE  = IFM_SIZE - KERNEL_SIZE + 1;
  localparam int XT        = IFM_SIZE / S;
  localparam int NO_TILING = XT * OFM_SIZE;
  localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CKK       = IFM_CHANNEL * KK;
  localparam int OW        = 2 * DATA_WIDTH;
  localparam int SB        = $clog2(CKK);
  localparam int RB        = $clog2(S);
`ifdef OFM_SAT_EN
  localparam int AW = OW + $clog2(CKK) + 1;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (OW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
`else
  localparam int AW = OW;
`endif

  logic                         load, comp, wr;
  logic [31:0]                  step, cf, ct, fbase, ty, tx0, ch, ky, kx;
  logic [31:0]                  ifm_addr, wgt_addr, ofm_addr;
  logic [INOUT_WIDTH-1:0]       ifm_rd;
  logic [S*DATA_WIDTH-1:0]      wgt_rd;
  logic [S-1:0]                 ofm_we;
  logic [S*OW-1:0]              ofm_wdat, ofm_rd_unused;
  logic signed [DATA_WIDTH-1:0] wbuf_q [BUFFER_COUNT][CKK];
  logic signed [AW-1:0]         acc_q  [S][S];
  logic signed [AW-1:0]         prod   [S][S];

  function automatic logic [OW-1:0] to_ofm(input logic signed [AW-1:0] v);
`ifdef OFM_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[OW-1:0];
    if (v < SAT_MIN) return SAT_MIN[OW-1:0];
`endif
    return v[OW-1:0];
  endfunction

  // Tiles scan x fastest; x tiles past the OFM edge are computed but never written.
  assign fbase    = cf * S;
  assign ty       = ct / XT;
  assign tx0      = (ct % XT) * S;
  assign ch       = step / KK;
  assign ky       = (step % KK) / KERNEL_SIZE;
  assign kx       = step % KERNEL_SIZE;
  assign ifm_addr = (ch * IFM_SIZE + ty + ky) * IFM_SIZE + tx0 + kx;
  assign wgt_addr = fbase * CKK + step;
  assign ofm_addr = ((fbase + step) * OFM_SIZE + ty) * OFM_SIZE + tx0;

  always_comb begin
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        prod[i][j] = AW'($signed(ifm_rd[j*DATA_WIDTH +: DATA_WIDTH])) * AW'(wbuf_q[i][step[SB-1:0]]);
  end

  always_comb begin
    ofm_we   = '0;
    ofm_wdat = '0;
    for (int j = 0; j < S; j++) begin
      ofm_we[j]              = wr && ((tx0 + 32'(j)) < 32'(OFM_SIZE));
      ofm_wdat[j*OW +: OW]   = to_ofm(acc_q[step[RB-1:0]][j]);
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      for (int i = 0; i < S; i++)
        wbuf_q[i][step[SB-1:0]] <= wgt_rd[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First tap of a tile overwrites the accumulator, clearing it per tile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++)
          acc_q[i][j] <= '0;
    end else if (comp) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++)
          acc_q[i][j] <= (step == 32'd0) ? prod[i][j] : acc_q[i][j] + prod[i][j];
    end
  end

  conv_ctrl #(.CKK(CKK), .S(S), .NO_TILING(NO_TILING), .NFG(NO_FILTER / S)) main_control (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .load_o(load), .comp_o(comp), .write_o(wr), .done_o(done),
    .step_o(step), .count_filter_o(cf), .count_tiling_o(ct)
  );

  conv_dpram #(.W(DATA_WIDTH), .DEPTH(IFM_CHANNEL * IFM_SIZE * IFM_SIZE), .LANES(S), .STRIDE(1)) dpram_ifm (
    .clk(clk), .we_i('0), .wr_addr_i('0), .wr_dat_i('0), .rd_addr_i(ifm_addr), .rd_dat_o(ifm_rd)
  );

  conv_dpram #(.W(DATA_WIDTH), .DEPTH(NO_FILTER * CKK), .LANES(S), .STRIDE(CKK)) dpram_wgt (
    .clk(clk), .we_i('0), .wr_addr_i('0), .wr_dat_i('0), .rd_addr_i(wgt_addr), .rd_dat_o(wgt_rd)
  );

  conv_dpram #(.W(OW), .DEPTH(NO_FILTER * OFM_SIZE * OFM_SIZE), .LANES(S), .STRIDE(1)) dpram_ofm (
    .clk(clk), .we_i(ofm_we), .wr_addr_i(ofm_addr), .wr_dat_i(ofm_wdat),
    .rd_addr_i('0), .rd_dat_o(ofm_rd_unused)
  );
endmodule

// Tile sequencer: IDLE -> LOAD_WGT -> (COMPUTE -> WRITE -> NEXT)* -> DONE.
module conv_ctrl #(
  parameter int CKK       = 144,
  parameter int S         = 16,
  parameter int NO_TILING = 2704,
  parameter int NFG       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic        load_o,
  output logic        comp_o,
  output logic        write_o,
  output logic        done_o,
  output logic [31:0] step_o,
  output logic [31:0] count_filter_o,
  output logic [31:0] count_tiling_o
);
  typedef enum logic [2:0] {IDLE, LOAD_WGT, COMPUTE, WRITE, NEXT, DONE} state_t;

  state_t      state_q;
  logic [31:0] step_q, count_filter, count_tiling;
  logic        done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      count_filter <= '0;
      count_tiling <= '0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= LOAD_WGT;
          step_q  <= '0;
        end
        LOAD_WGT: if (step_q == 32'(CKK - 1)) begin
          step_q  <= '0;
          state_q <= COMPUTE;
        end else step_q <= step_q + 32'd1;
        COMPUTE: if (step_q == 32'(CKK - 1)) begin
          step_q  <= '0;
          state_q <= WRITE;
        end else step_q <= step_q + 32'd1;
        WRITE: if (step_q == 32'(S - 1)) begin
          step_q  <= '0;
          state_q <= NEXT;
        end else step_q <= step_q + 32'd1;
        NEXT: if (count_tiling == 32'(NO_TILING - 1)) begin
          count_tiling <= '0;
          if (count_filter == 32'(NFG - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            count_filter <= count_filter + 32'd1;
            state_q      <= LOAD_WGT;
          end
        end else begin
          count_tiling <= count_tiling + 32'd1;
          state_q      <= COMPUTE;
        end
        DONE: if (start_i) begin
          state_q      <= LOAD_WGT;
          done_q       <= 1'b0;
          step_q       <= '0;
          count_filter <= '0;
          count_tiling <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_o         = (state_q == LOAD_WGT);
  assign comp_o         = (state_q == COMPUTE);
  assign write_o        = (state_q == WRITE);
  assign done_o         = done_q;
  assign step_o         = step_q;
  assign count_filter_o = count_filter;
  assign count_tiling_o = count_tiling;
endmodule

// Word memory with a multi-lane strided combinational read and per-lane write enables; reads past the end give 0.
module conv_dpram #(
  parameter int W      = 8,
  parameter int DEPTH  = 16,
  parameter int LANES  = 1,
  parameter int STRIDE = 1
) (
  input  logic               clk,
  input  logic [LANES-1:0]   we_i,
  input  logic [31:0]        wr_addr_i,
  input  logic [LANES*W-1:0] wr_dat_i,
  input  logic [31:0]        rd_addr_i,
  output logic [LANES*W-1:0] rd_dat_o
);
  localparam int AB = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (we_i[l] && ((wr_addr_i + 32'(l * STRIDE)) < 32'(DEPTH)))
        mem[AB'(wr_addr_i + 32'(l * STRIDE))] <= wr_dat_i[l*W +: W];
  end

  always_comb begin
    rd_dat_o = '0;
    for (int l = 0; l < LANES; l++)
      if ((rd_addr_i + 32'(l * STRIDE)) < 32'(DEPTH))
        rd_dat_o[l*W +: W] = mem[AB'(rd_addr_i + 32'(l * STRIDE))];
  end
endmodule

// File: tb/tb_conv_accel_top.sv
// Directed/randomized bench for conv_accel_top on a reduced geometry, checked against a plain-arithmetic golden model.
module tb_conv_accel_top;
  localparam int S = 2, BC = 2, DW = 8, IOW = 16, ISZ = 6, C = 2, K = 3, NF = 4;
  localparam int O = ISZ - K + 1, NT = (ISZ / S) * O, CKK = C * K * K;
  localparam int NIFM = C * ISZ * ISZ, NWGT = NF * CKK, NOFM = NF * O * O;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic done;
  int   checks = 0, errors = 0;
  int   ifm_m [NIFM];
  int   wgt_m [NWGT];

  always #5 clk = ~clk;

  conv_accel_top #(
    .SYSTOLIC_SIZE(S), .BUFFER_COUNT(BC), .DATA_WIDTH(DW), .INOUT_WIDTH(IOW),
    .IFM_SIZE(ISZ), .IFM_CHANNEL(C), .KERNEL_SIZE(K), .NO_FILTER(NF)
  ) dut (.clk(clk), .rst_n(rst_n), .start(start), .done(done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] golden(input int f, input int y, input int x);
    longint s = 0;
    for (int c = 0; c < C; c++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          s += longint'(ifm_m[(c * ISZ + y + ky) * ISZ + x + kx]) *
               longint'(wgt_m[((f * C + c) * K + ky) * K + kx]);
`ifdef OFM_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic set_ifm(input bit rnd, input int val);
    for (int a = 0; a < NIFM; a++) begin
      ifm_m[a] = rnd ? (int'($urandom_range(0, 255)) - 128) : val;
      dut.dpram_ifm.mem[a] = 8'(ifm_m[a]);
    end
  endtask

  task automatic set_wgt(input bit rnd, input int val_lo, input int val_hi);
    for (int a = 0; a < NWGT; a++) begin
      if (rnd) wgt_m[a] = int'($urandom_range(0, 255)) - 128;
      else     wgt_m[a] = (a / CKK < S) ? val_lo : val_hi;
      dut.dpram_wgt.mem[a] = 8'(wgt_m[a]);
    end
  endtask

  task automatic clear_ofm();
    for (int a = 0; a < NOFM; a++) dut.dpram_ofm.mem[a] = 16'hDEAD;
  endtask

  task automatic check_ofm(input string tag);
    for (int f = 0; f < NF; f++)
      for (int y = 0; y < O; y++)
        for (int x = 0; x < O; x++)
          check($sformatf("%s_ofm[f%0d,y%0d,x%0d]", tag, f, y, x),
                32'(dut.dpram_ofm.mem[(f * O + y) * O + x]), 32'(golden(f, y, x)));
  endtask

  task automatic run_conv(input bit extra_start, input string tag);
    int rises = 0, maxt = 0, nonmono = 0, gprev = 0, after = 0, g;
    bit dprev = done;
    for (int cyc = 0; cyc < 3000 && after < 10; cyc++) begin
      @(negedge clk);
      if (!done) begin
        g = int'(dut.main_control.count_filter) * NT + int'(dut.main_control.count_tiling);
        if (g < gprev) nonmono++;
        gprev = g;
        if (int'(dut.main_control.count_tiling) > maxt) maxt = int'(dut.main_control.count_tiling);
      end
      if (done && !dprev) rises++;
      dprev = done;
      if (rises > 0) after++;
      start = (cyc < 2) || (extra_start && cyc == 60);
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_rises"}, 32'(rises), 32'd1);
    check({tag, "_max_tiling"}, 32'(maxt), 32'(NT - 1));
    check({tag, "_monotonic"}, 32'(nonmono), 32'd0);
    check_ofm(tag);
  endtask

  initial begin
    bit reached = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count_filter", dut.main_control.count_filter, 32'd0);
    check("rst_count_tiling", dut.main_control.count_tiling, 32'd0);
    check("rst_acc", 32'(dut.acc_q[0][0]), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(done), 32'd0);

    set_ifm(1'b1, 0); set_wgt(1'b1, 0, 0); clear_ofm();
    run_conv(1'b1, "rand");

    set_ifm(1'b0, 1); set_wgt(1'b0, 1, 1); clear_ofm();
    run_conv(1'b0, "ones");
    check("ones_lit", 32'(dut.dpram_ofm.mem[0]), 32'h0012);

    set_wgt(1'b0, 1, -1); clear_ofm();
    run_conv(1'b0, "neg");
    check("neg_lit_f0", 32'(dut.dpram_ofm.mem[0]), 32'h0012);
    check("neg_lit_f2", 32'(dut.dpram_ofm.mem[2 * O * O]), 32'hFFEE);

    set_ifm(1'b0, 127); set_wgt(1'b0, 127, 127); clear_ofm();
    run_conv(1'b0, "pos_big");
`ifdef OFM_SAT_EN
    check("pos_big_lit", 32'(dut.dpram_ofm.mem[5]), 32'h7FFF);
`else
    check("pos_big_lit", 32'(dut.dpram_ofm.mem[5]), 32'h6E12);
`endif

    set_wgt(1'b0, -128, -128); clear_ofm();
    run_conv(1'b0, "neg_big");
`ifdef OFM_SAT_EN
    check("neg_big_lit", 32'(dut.dpram_ofm.mem[0]), 32'h8000);
`else
    check("neg_big_lit", 32'(dut.dpram_ofm.mem[0]), 32'h8900);
`endif

    set_ifm(1'b1, 0); set_wgt(1'b1, 0, 0); clear_ofm();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = (i < 2);
      if (dut.main_control.count_filter == 32'd1 && dut.main_control.count_tiling == 32'd2) begin
        reached = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("midrun_reached", 32'(reached), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_count_filter", dut.main_control.count_filter, 32'd0);
    check("midrst_count_tiling", dut.main_control.count_tiling, 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_idle", 32'(done), 32'd0);
    clear_ofm();
    run_conv(1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
